// File: rtl/noc_out_port_arbiter.sv
// noc_out_port_arbiter: wormhole output-port arbiter for one router output.
// Round-robin packet-level fairness across NUM_REQ inputs, downstream
// credit tracking and crossbar select generation.
// Optional per-input packet counters are built when NOC_ARB_STATS_EN is defined.
module noc_out_port_arbiter #(
  parameter  int NUM_REQ = 5,
  parameter  int CREDITS = 4,
  localparam int SEL_W   = $clog2(NUM_REQ),
  localparam int CRD_W   = $clog2(CREDITS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] tail,
  input  logic               credit_ret,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               out_vld,
  output logic               busy,
  output logic [CRD_W-1:0]   credit_cnt,
  output logic               credit_err
`ifdef NOC_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] pkt_cnt
`endif
);

  localparam logic [0:0]       IDLE    = 1'b0;
  localparam logic [0:0]       LOCKED  = 1'b1;
  localparam int unsigned      NREQ_U  = NUM_REQ;
  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(CREDITS);
  localparam logic [SEL_W-1:0] LAST    = SEL_W'(NUM_REQ - 1);

  logic [0:0]       state;
  logic [SEL_W-1:0] owner;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] pick;
  logic             found;
  logic             has_credit;
  logic             tail_xfer;
  int unsigned      idx;

  assign has_credit = (credit_cnt != '0);
  assign tail_xfer  = |(gnt & tail);
  assign out_vld    = |gnt;
  assign busy       = (state == LOCKED);
  assign sel        = owner;

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NREQ_U) idx = idx - NREQ_U;
      if (!found && req[SEL_W'(idx)]) begin
        found = 1'b1;
        pick  = SEL_W'(idx);
      end
    end
  end

  // Grant only the locked owner, and only when a downstream slot is free.
  always_comb begin
    gnt = '0;
    if (state == LOCKED && req[owner] && has_credit) gnt[owner] = 1'b1;
  end

  // Packet FSM: lock onto the picked input, release after its tail flit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found && has_credit) begin
            owner <= pick;
            state <= LOCKED;
          end
        end
        default: begin
          if (tail_xfer) begin
            state  <= IDLE;
            rr_ptr <= (owner == LAST) ? '0 : owner + 1'b1;
          end
        end
      endcase
    end
  end

  // Credit counter; a return arriving with a full counter is flagged and dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt <= CRD_MAX;
      credit_err <= 1'b0;
    end else if (credit_ret && !out_vld) begin
      if (credit_cnt == CRD_MAX) credit_err <= 1'b1;
      else                       credit_cnt <= credit_cnt + 1'b1;
    end else if (out_vld && !credit_ret) begin
      credit_cnt <= credit_cnt - 1'b1;
    end
  end

`ifdef NOC_ARB_STATS_EN
  // Per-input count of completed packets (tail flits transferred), wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ_U; i++) begin
        if (gnt[i] && tail[i]) pkt_cnt[16*i +: 16] <= pkt_cnt[16*i +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Self-checking bench for noc_out_port_arbiter (NUM_REQ=5, CREDITS=4).
module tb_noc_out_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req;
  logic [4:0]  tail;
  logic        credit_ret;
  logic [4:0]  gnt;
  logic [2:0]  sel;
  logic        out_vld;
  logic        busy;
  logic [2:0]  credit_cnt;
  logic        credit_err;
`ifdef NOC_ARB_STATS_EN
  logic [79:0] pkt_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  noc_out_port_arbiter #(.NUM_REQ(5), .CREDITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .tail       (tail),
    .credit_ret (credit_ret),
    .gnt        (gnt),
    .sel        (sel),
    .out_vld    (out_vld),
    .busy       (busy),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
`ifdef NOC_ARB_STATS_EN
    ,
    .pkt_cnt    (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [4:0] req;
    logic [4:0] tail;
    logic       cr;
    logic [4:0] gnt;
    logic       busy;
    logic [2:0] sel;
    logic [2:0] cnt;
    logic       err;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] r, input logic [4:0] t, input logic c);
    req = r; tail = t; credit_ret = c;
    #1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0; tail = '0; credit_ret = 1'b0;
    adv();
    adv();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] pack_exp(input vec_t v);
    return {v.gnt, |v.gnt, v.busy, v.sel, v.cnt, v.err, 2'b00};
  endfunction

  function automatic logic [15:0] pack_act();
    return {gnt, out_vld, busy, sel, credit_cnt, credit_err, 2'b00};
  endfunction

  int gcount;
  logic [4:0] exp_g;
  logic       prev_g;

  initial begin
    //            req       tail      cr    gnt       busy  sel   cnt   err
    vecs[0]  = '{5'b00101, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd0, 3'd4, 1'b0};
    vecs[1]  = '{5'b00101, 5'b00000, 1'b1, 5'b00001, 1'b1, 3'd0, 3'd4, 1'b0};
    vecs[2]  = '{5'b00101, 5'b00000, 1'b1, 5'b00001, 1'b1, 3'd0, 3'd4, 1'b0};
    vecs[3]  = '{5'b00101, 5'b00001, 1'b1, 5'b00001, 1'b1, 3'd0, 3'd4, 1'b0};
    vecs[4]  = '{5'b00101, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd0, 3'd4, 1'b0};
    vecs[5]  = '{5'b00101, 5'b00000, 1'b1, 5'b00100, 1'b1, 3'd2, 3'd4, 1'b0};
    vecs[6]  = '{5'b00101, 5'b00000, 1'b1, 5'b00100, 1'b1, 3'd2, 3'd4, 1'b0};
    vecs[7]  = '{5'b00101, 5'b00100, 1'b1, 5'b00100, 1'b1, 3'd2, 3'd4, 1'b0};
    vecs[8]  = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd2, 3'd4, 1'b0};
    vecs[9]  = '{5'b11111, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd2, 3'd4, 1'b0};
    vecs[10] = '{5'b11111, 5'b01000, 1'b1, 5'b01000, 1'b1, 3'd3, 3'd4, 1'b0};
    vecs[11] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd3, 3'd4, 1'b0};
    vecs[12] = '{5'b00001, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd3, 3'd4, 1'b0};
    vecs[13] = '{5'b00001, 5'b00000, 1'b0, 5'b00001, 1'b1, 3'd0, 3'd4, 1'b0};
    vecs[14] = '{5'b00001, 5'b00000, 1'b0, 5'b00001, 1'b1, 3'd0, 3'd3, 1'b0};
    vecs[15] = '{5'b00001, 5'b00000, 1'b1, 5'b00001, 1'b1, 3'd0, 3'd2, 1'b0};
    vecs[16] = '{5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b1, 3'd0, 3'd2, 1'b0};
    vecs[17] = '{5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b1, 3'd0, 3'd3, 1'b0};
    vecs[18] = '{5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b1, 3'd0, 3'd4, 1'b0};
    vecs[19] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b1, 3'd0, 3'd4, 1'b1};
    vecs[20] = '{5'b00001, 5'b00001, 1'b0, 5'b00001, 1'b1, 3'd0, 3'd4, 1'b1};
    vecs[21] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd0, 3'd3, 1'b1};

    // Reset values
    rst = 1'b1;
    req = '0; tail = '0; credit_ret = 1'b0;
    #2;
    chk("reset_outputs", 32'(pack_act()), 32'({5'b0, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0, 2'b00}));
    adv();
    adv();
    rst = 1'b0;

    // Table: two packets round-robin, rr_ptr advance, credit accounting and saturation
    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].tail, vecs[i].cr);
      chk($sformatf("vec%0d", i), 32'(pack_act()), 32'(pack_exp(vecs[i])));
      adv();
    end

    // Async reset mid-packet: owner=2 with one credit left
    do_reset();
    drive(5'b00100, 5'b0, 1'b0);
    adv();
    for (int i = 0; i < 3; i++) begin
      drive(5'b00100, 5'b0, 1'b0);
      adv();
    end
    drive(5'b00100, 5'b0, 1'b0);
    chk("midpkt_state", {27'b0, gnt}, 32'b00100);
    chk("midpkt_cnt", 32'(credit_cnt), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_now", 32'(pack_act()), 32'({5'b0, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0, 2'b00}));
    adv();
    chk("async_rst_edge", 32'(pack_act()), 32'({5'b0, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0, 2'b00}));
    rst = 1'b0;
    drive(5'b00100, 5'b0, 1'b0);
    chk("post_rst_idle_gnt", {27'b0, gnt}, 32'b0);
    adv();

    // Credit stall: owner=1, 5-flit packet, no returns
    do_reset();
    drive(5'b00010, 5'b0, 1'b0);
    adv();
    gcount = 0;
    for (int i = 0; i < 6; i++) begin
      drive(5'b00010, 5'b0, 1'b0);
      if (gnt == 5'b00010) gcount++;
      adv();
    end
    chk("stall_gnts", 32'(gcount), 32'd4);
    drive(5'b00010, 5'b0, 1'b1);
    chk("stall_busy_cnt", {28'b0, busy, credit_cnt}, {28'b0, 1'b1, 3'd0});
    adv();
    gcount = 0;
    for (int i = 0; i < 4; i++) begin
      drive(5'b00010, 5'b00010, 1'b0);
      if (gnt == 5'b00010) gcount++;
      adv();
    end
    chk("stall_one_more", 32'(gcount), 32'd1);
    chk("stall_end_busy", 32'(busy), 32'd0);

    // All inputs, single-flit packets: order 0,1,2,3,4,0 two cycles apart
    do_reset();
    prev_g = 1'b0;
    for (int k = 0; k < 12; k++) begin
      drive(5'b11111, 5'b11111, prev_g);
      exp_g = (k % 2 == 1) ? 5'(1 << ((k / 2) % 5)) : 5'b0;
      chk($sformatf("rr_all_c%0d", k), {27'b0, gnt}, {27'b0, exp_g});
      prev_g = out_vld;
      adv();
    end
`ifdef NOC_ARB_STATS_EN
    chk("pkt_cnt", pkt_cnt[79:0] == {16'd1, 16'd1, 16'd1, 16'd1, 16'd2} ? 32'd1 : 32'd0, 32'd1);
`endif

    // Owner drops req; other requesters must not interrupt
    do_reset();
    drive(5'b01000, 5'b0, 1'b0);
    adv();
    drive(5'b01001, 5'b0, 1'b0);
    chk("own3_first", {27'b0, gnt}, 32'b01000);
    adv();
    for (int i = 0; i < 3; i++) begin
      drive(5'b00001, 5'b0, 1'b0);
      chk($sformatf("own3_drop%0d", i), {26'b0, busy, gnt}, {26'b0, 1'b1, 5'b0});
      adv();
    end
    drive(5'b01001, 5'b01001, 1'b0);
    chk("own3_tail", {26'b0, busy, gnt}, {26'b0, 1'b1, 5'b01000});
    adv();
    drive(5'b00001, 5'b0, 1'b0);
    chk("own3_released", {26'b0, busy, gnt}, {26'b0, 1'b0, 5'b0});
    adv();
    drive(5'b00001, 5'b00001, 1'b0);
    chk("in0_after", {23'b0, sel, busy, gnt}, {23'b0, 3'd0, 1'b1, 5'b00001});
    adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
